// File: rtl/dbs_pkg.sv
// dbs_pkg: shared constants and types for the deadband scan scheduler.
//   W      - sample and baseline width in bits
//   N_CH   - number of requester channels (fixed at 4, 2-bit channel id)
//   THRESH - deadband; a sample is an event only when |sample - baseline| > THRESH
package dbs_pkg;

    localparam int W      = 8;
    localparam int N_CH   = 4;
    localparam int THRESH = 2;

    typedef logic [1:0]   ch_t;
    typedef logic [W-1:0] sample_t;

    typedef struct packed {
        ch_t     ch;
        sample_t data;
        sample_t delta;
    } ev_t;

    // Unsigned absolute difference; the subtraction order keeps it inside W bits.
    function automatic sample_t abs_diff(input sample_t a, input sample_t b);
        return (a >= b) ? sample_t'(a - b) : sample_t'(b - a);
    endfunction

endpackage

// File: rtl/deadband_scan_sched_rr_arb4.sv
// rr_arb4: four-request round-robin arbiter.
//   clk, rst_n - clock; asynchronous reset, active-high
//   req[3:0]   - request vector
//   en         - a grant may be issued this cycle
//   gnt[3:0]   - one-hot grant (all zero when en is low or nothing requests)
//   id         - encoded index of the winning request
// The priority pointer moves to (winner + 1) mod 4 after every grant.
module rr_arb4
    import dbs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       en,
    output logic [3:0] gnt,
    output ch_t        id
);

    ch_t  ptr_q, ptr_d;
    ch_t  idx;
    logic found;

    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        found = 1'b0;
        id    = '0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            // 2-bit addition wraps, giving the rotated search order.
            idx = ptr_q + ch_t'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
        gnt   = (en && found) ? (4'b0001 << id) : 4'b0000;
        ptr_d = (en && found) ? ch_t'(id + 2'd1) : ptr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/deadband_scan_sched.sv
// deadband_scan_sched: four one-entry input slots, a round-robin grant into a
// single compare stage (S1) holding per-channel baselines, and a registered
// event output with a saturating event counter.
//   clk, rst_n         - clock; asynchronous reset, active-high
//   in_valid[3:0]      - per-channel sample valid
//   in_data[31:0]      - per-channel samples, channel i at [i*W +: W]
//   in_ready[3:0]      - per-channel ready (registered: slot empty)
//   ev_valid, ev_ready - event output handshake
//   ev_ch, ev_data     - channel and sample of the event
//   ev_delta           - |sample - old baseline|
//   ev_cnt             - events issued, saturating at 0xFFFF
module deadband_scan_sched
    import dbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              ev_valid,
    input  logic              ev_ready,
    output ch_t               ev_ch,
    output sample_t           ev_data,
    output sample_t           ev_delta,
    output logic [15:0]       ev_cnt
);

    logic [N_CH-1:0]            slot_valid_q, slot_valid_d;
    sample_t [N_CH-1:0]         slot_data_q,  slot_data_d;
    logic                       s1_valid_q,   s1_valid_d;
    ch_t                        s1_ch_q,      s1_ch_d;
    sample_t                    s1_data_q,    s1_data_d;
    sample_t [N_CH-1:0]         base_q,       base_d;
    logic                       ev_valid_q,   ev_valid_d;
    ev_t                        ev_q,         ev_d;
    logic [15:0]                ev_cnt_q,     ev_cnt_d;

    sample_t    delta;
    logic       is_event, out_free, s1_retire, arb_en;
    logic [3:0] gnt;
    ch_t        gnt_id;

    assign delta     = abs_diff(s1_data_q, base_q[s1_ch_q]);
    assign is_event  = delta > sample_t'(THRESH);
    assign out_free  = !ev_valid_q || ev_ready;
    // Non-events always retire; events need the output register to be free.
    assign s1_retire = s1_valid_q && (!is_event || out_free);
    assign arb_en    = !s1_valid_q || s1_retire;

    rr_arb4 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (slot_valid_q),
        .en    (arb_en),
        .gnt   (gnt),
        .id    (gnt_id)
    );

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        s1_valid_d   = s1_valid_q;
        s1_ch_d      = s1_ch_q;
        s1_data_d    = s1_data_q;
        base_d       = base_q;
        ev_valid_d   = ev_valid_q;
        ev_d         = ev_q;
        ev_cnt_d     = ev_cnt_q;

        for (int i = 0; i < N_CH; i++) begin
            if (in_valid[i] && !slot_valid_q[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_data_d[i]  = in_data[i*W +: W];
            end
        end
        // Only full slots are granted, so this never cancels a same-cycle load.
        slot_valid_d = slot_valid_d & ~gnt;

        if (|gnt) begin
            s1_valid_d = 1'b1;
            s1_ch_d    = gnt_id;
            s1_data_d  = slot_data_q[gnt_id];
        end else if (s1_retire) begin
            s1_valid_d = 1'b0;
        end

        if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;

        if (s1_retire && is_event) begin
            base_d[s1_ch_q] = s1_data_q;
            ev_valid_d      = 1'b1;
            ev_d.ch         = s1_ch_q;
            ev_d.data       = s1_data_q;
            ev_d.delta      = delta;
            if (ev_cnt_q != 16'hFFFF) ev_cnt_d = ev_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            slot_valid_q <= '0;
            slot_data_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_ch_q      <= '0;
            s1_data_q    <= '0;
            // NOTE: the baseline array is reset on purpose: compares after reset
            // are defined against zero, so it cannot be left uninitialised.
            base_q       <= '0;
            ev_valid_q   <= 1'b0;
            ev_q         <= '0;
            ev_cnt_q     <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            s1_valid_q   <= s1_valid_d;
            s1_ch_q      <= s1_ch_d;
            s1_data_q    <= s1_data_d;
            base_q       <= base_d;
            ev_valid_q   <= ev_valid_d;
            ev_q         <= ev_d;
            ev_cnt_q     <= ev_cnt_d;
        end
    end

    assign in_ready = ~slot_valid_q;
    assign ev_valid = ev_valid_q;
    assign ev_ch    = ev_q.ch;
    assign ev_data  = ev_q.data;
    assign ev_delta = ev_q.delta;
    assign ev_cnt   = ev_cnt_q;

endmodule

// File: tb/tb_deadband_scan_sched.sv
// Self-checking bench for deadband_scan_sched: a transaction-level model of
// slots, the compare stage, baselines and the output register is advanced once
// per clock and compared against every DUT output on each falling edge; a few
// directed scenarios add literal expectations.
module tb_deadband_scan_sched;
    import dbs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        ev_valid;
    logic        ev_ready;
    logic [1:0]  ev_ch;
    logic [7:0]  ev_data;
    logic [7:0]  ev_delta;
    logic [15:0] ev_cnt;

    deadband_scan_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ch    (ev_ch),
        .ev_data  (ev_data),
        .ev_delta (ev_delta),
        .ev_cnt   (ev_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_slot_full [4];
    int m_slot_val  [4];
    bit m_s1_full;
    int m_s1_ch, m_s1_val;
    int m_ptr;
    int m_base [4];
    bit m_ev_valid;
    int m_ev_ch, m_ev_data, m_ev_delta;
    int m_cnt;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_slot_full[c] = 0; m_slot_val[c] = 0; m_base[c] = 0;
        end
        m_s1_full = 0; m_s1_ch = 0; m_s1_val = 0; m_ptr = 0;
        m_ev_valid = 0; m_ev_ch = 0; m_ev_data = 0; m_ev_delta = 0; m_cnt = 0;
    endtask

    // One clock edge worth of behaviour, using the inputs present at that edge.
    task automatic model_step(output logic [3:0] acc);
        int  d;
        bit  fire, done;
        acc = '0;
        for (int c = 0; c < 4; c++) if (in_valid[c] && !m_slot_full[c]) acc[c] = 1'b1;
        d = 0; fire = 0; done = 0;
        if (m_s1_full) begin
            d = m_s1_val - m_base[m_s1_ch];
            if (d < 0) d = -d;
            fire = (d > THRESH);
            done = !fire || !m_ev_valid || ev_ready;
        end
        if (m_ev_valid && ev_ready) m_ev_valid = 0;
        if (done && fire) begin
            m_ev_valid = 1; m_ev_ch = m_s1_ch; m_ev_data = m_s1_val; m_ev_delta = d;
            m_base[m_s1_ch] = m_s1_val;
            if (m_cnt < 65535) m_cnt++;
        end
        if (done) m_s1_full = 0;
        if (!m_s1_full) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_slot_full[c]) begin
                    m_s1_full = 1; m_s1_ch = c; m_s1_val = m_slot_val[c];
                    m_slot_full[c] = 0; m_ptr = (c + 1) % 4;
                    break;
                end
            end
        end
        for (int c = 0; c < 4; c++) if (acc[c]) begin
            m_slot_full[c] = 1; m_slot_val[c] = int'(in_data[c*8 +: 8]);
        end
    endtask

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = !m_slot_full[c];
        return r;
    endfunction

    // Single compare process: every DUT output against the model, every cycle.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("ev_valid", 32'(ev_valid), 32'(m_ev_valid));
        check("ev_ch",    32'(ev_ch),    32'(m_ev_ch));
        check("ev_data",  32'(ev_data),  32'(m_ev_data));
        check("ev_delta", 32'(ev_delta), 32'(m_ev_delta));
        check("ev_cnt",   32'(ev_cnt),   32'(m_cnt));
    end

    // ---------------- stimulus helpers ----------------
    logic [3:0] acc;
    logic [7:0] tog [4];

    task automatic step(output logic [3:0] a);
        @(posedge clk);
        #1;
        if (rst_n) begin model_reset(); a = '0; end
        else model_step(a);
    endtask

    task automatic send(input int c, input logic [7:0] v, input int idle);
        logic [3:0] a;
        in_valid = '0;
        in_valid[c] = 1'b1;
        in_data[c*8 +: 8] = v;
        step(a);
        in_valid = '0;
        repeat (idle) step(a);
    endtask

    task automatic do_reset();
        logic [3:0] a;
        rst_n = 1'b1;
        model_reset();
        #1;
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        check("rst_ev_cnt",   32'(ev_cnt),   32'h0);
        check("rst_in_ready", 32'(in_ready), 32'hF);
        in_valid = '0;
        repeat (2) step(a);
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) tog[c] = 8'h80;
    endtask

    task automatic run_toggle(input int n, input logic rdy);
        logic [3:0] a;
        in_valid = 4'hF;
        ev_ready = rdy;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) in_data[c*8 +: 8] = tog[c];
            step(a);
            for (int c = 0; c < 4; c++) if (a[c]) tog[c] = tog[c] ^ 8'h80;
        end
    endtask

    int rec [8];
    int nrec;
    int nev;
    bit pend [4];

    initial begin
        rst_n = 1'b1; in_valid = '0; in_data = '0; ev_ready = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) tog[c] = 8'h80;
        repeat (3) step(acc);
        rst_n = 1'b0;

        // Single sample: event appears two edges after the handshake.
        send(1, 8'h05, 0);
        step(acc);
        check("single_not_yet", 32'(ev_valid), 32'h0);
        step(acc);
        check("single_valid", 32'(ev_valid), 32'h1);
        check("single_ch",    32'(ev_ch),    32'h1);
        check("single_data",  32'(ev_data),  32'h05);
        check("single_delta", 32'(ev_delta), 32'h05);
        check("single_cnt",   32'(ev_cnt),   32'h1);
        repeat (2) step(acc);

        // Deadband: only 0x10 is an event; 0x12 and 0x0E sit exactly on THRESH.
        send(0, 8'h10, 4);
        send(0, 8'h12, 4);
        send(0, 8'h0E, 4);
        check("db_cnt",   32'(ev_cnt),   32'h2);
        check("db_data",  32'(ev_data),  32'h10);
        check("db_valid", 32'(ev_valid), 32'h0);
        send(0, 8'h13, 0);
        repeat (2) step(acc);
        check("db_base_valid", 32'(ev_valid), 32'h1);
        check("db_base_delta", 32'(ev_delta), 32'h03);
        check("db_base_data",  32'(ev_data),  32'h13);
        check("db_base_cnt",   32'(ev_cnt),   32'h3);
        repeat (2) step(acc);

        // Fairness: all channels request continuously.
        do_reset();
        nrec = 0;
        in_valid = 4'hF; ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 4; c++) in_data[c*8 +: 8] = tog[c];
            step(acc);
            for (int c = 0; c < 4; c++) if (acc[c]) tog[c] = tog[c] ^ 8'h80;
            if (ev_valid && nrec < 8) begin rec[nrec] = int'(ev_ch); nrec++; end
        end
        check("fair_count", 32'(nrec), 32'd8);
        for (int i = 0; i < 8; i++) check("fair_order", 32'(rec[i]), 32'(i % 4));

        // Backpressure: stall, slots fill, then drain exactly six events.
        run_toggle(12, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        check("bp_valid",    32'(ev_valid), 32'h1);
        in_valid = '0; ev_ready = 1'b1;
        nev = ev_valid ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            step(acc);
            if (ev_valid) nev++;
        end
        check("bp_drained", 32'(nev), 32'd6);

        // Reset while S1 and the output register are occupied.
        run_toggle(6, 1'b0);
        do_reset();
        check("rr_in_ready", 32'(in_ready), 32'hF);
        ev_ready = 1'b1;
        step(acc);
        send(2, 8'h03, 0);
        repeat (2) step(acc);
        check("rr_valid", 32'(ev_valid), 32'h1);
        check("rr_ch",    32'(ev_ch),    32'h2);
        check("rr_data",  32'(ev_data),  32'h03);
        check("rr_delta", 32'(ev_delta), 32'h03);
        check("rr_cnt",   32'(ev_cnt),   32'h1);

        // Random traffic with random backpressure; the model checks every cycle.
        for (int c = 0; c < 4; c++) pend[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) if (!pend[c]) begin
                in_valid[c] = ($urandom_range(0, 1) == 1);
                in_data[c*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6))
                                                                 : 8'($urandom_range(0, 255));
            end
            ev_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            for (int c = 0; c < 4; c++) pend[c] = in_valid[c] && !acc[c];
        end
        in_valid = '0; ev_ready = 1'b1;
        repeat (8) step(acc);

        // Counter saturation.
        run_toggle(66000, 1'b1);
        check("sat_cnt", 32'(ev_cnt), 32'hFFFF);
        run_toggle(20, 1'b1);
        check("sat_hold",  32'(ev_cnt),   32'hFFFF);
        check("sat_valid", 32'(ev_valid), 32'h1);

        in_valid = '0;
        repeat (4) step(acc);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deadband_scan_sched.md
# deadband_scan_sched

Round-robin scheduler and shared compare engine for the four-channel deadband change detector. Four independent requesters each submit samples over valid/ready. The block arbitrates them into one compare stage that holds a per-channel baseline. Only samples differing from their channel's baseline by more than a threshold produce an event; those samples also become the new baseline. Events leave through a registered valid/ready port toward the output/pin logic.

## Interface
Parameters:
- W, 8, sample and baseline width in bits
- N_CH, 4, number of requester channels; fixed at 4, so the channel id is 2 bits
- THRESH, 2, deadband; an event is produced only when the difference is strictly greater than THRESH

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- in_valid  in  N_CH  per-channel sample valid
- in_data  in  N_CH*W  per-channel samples; channel i occupies bits [i*W +: W]
- in_ready  out  N_CH  per-channel ready
- ev_valid  out  1  event valid
- ev_ready  in  1  event consumer ready
- ev_ch  out  2  channel id of the event
- ev_data  out  W  sample that triggered the event
- ev_delta  out  W  absolute difference between the sample and the old baseline
- ev_cnt  out  16  total events issued; saturates at 0xFFFF

## Operation
- Per-channel slot: a one-entry buffer.
  - in_ready[i] = !slot_valid[i]; it is a pure register output with no combinational path from in_valid.
  - A handshake (in_valid[i] && in_ready[i]) at an edge loads the slot.
- Arbiter:
  - Round-robin over slot_valid, one grant per cycle.
  - Priority pointer starts at 0. After a grant to channel g, the pointer becomes (g+1) mod 4.
  - A grant fires only when stage S1 is empty or retiring in the same cycle.
- Slot release on grant:
  - The granted slot clears at the same edge that loads S1.
  - in_ready[g] rises the following cycle; there is no same-cycle refill.
- Stage S1: holds {ch, data}.
  - delta = (data >= base[ch]) ? data - base[ch] : base[ch] - data, computed unsigned in W bits with no overflow.
  - delta > THRESH: this is an event. S1 retires only if the output register is free (!ev_valid || ev_ready). At retirement, base[ch] <= data, the output register loads {ch, data, delta}, and ev_cnt increments with saturation.
  - delta <= THRESH, including equality (delta 0): S1 retires unconditionally. There is no event and base[ch] is unchanged.
  - When S1 cannot retire, S1 and the arbiter stall. Slots keep accepting until they are full.
- Back-to-back samples on one channel:
  - The baseline updates at S1 retirement.
  - A following sample of the same channel enters S1 at that same edge and compares against the updated baseline the next cycle. No bypass is needed.
- Output register:
  - ev_valid stays high and ev_ch/ev_data/ev_delta stay stable until ev_ready.
  - A new event may load at the same edge the old one is accepted.
- Reset (asynchronous, any time, including mid-transfer):
  - All slots empty, so in_ready = 4'b1111 after reset releases.
  - S1 empty; pointer = 0; all baselines = 0.
  - ev_valid = 0, ev_ch = 0, ev_data = 0, ev_delta = 0, ev_cnt = 0.
  - In-flight samples are discarded.

## Timing
- Latency from input handshake edge E0 to event:
  - E1: grant, S1 loaded.
  - E2: output register loaded.
  - ev_valid is high in the cycle after E2, i.e. 2 edges after the input handshake when uncontended.
- Throughput: one compare per cycle across all channels while ev_ready is high.
- Per-channel rate: at most one sample every 2 cycles, because of the one-entry slot.
- Worst-case wait: a full slot is granted within 4 cycles of S1 becoming free.
- Registered outputs: all of them. There is no combinational path from any input to any output.

## Structure
- Package dbs_pkg holds:
  - localparams W, N_CH, THRESH
  - typedef ch_t (2-bit channel id)
  - typedef sample_t (W bits)
  - struct ev_t {ch, data, delta}
- Sub-module rr_arb4: 4-request round-robin arbiter.
  - Inputs: req[3:0], en.
  - Outputs: one-hot gnt, encoded id.
  - Contains the pointer register and the same asynchronous active-high reset.
- The top level holds the slots, S1, the baseline array, the output register and the counter.

## Test plan
- Reset then single sample: ch1 = 0x05 with ev_ready = 1. Expect ev_valid 2 edges later with ev_ch = 1, ev_data = 0x05, ev_delta = 0x05, ev_cnt = 1.
- Deadband: ch0 = 0x10, then ch0 = 0x12, then ch0 = 0x0E. Expect one event only (for 0x10). The 0x12 and 0x0E samples (delta 2) give no event, and base[0] stays 0x10.
- Fairness: all four channels valid every cycle with values that trigger events. Expect ev_ch sequence 0,1,2,3,0,… with no channel starved.
- Backpressure: hold ev_ready = 0 with an event pending. Expect ev_valid and its fields stable, S1 stalled, and in_ready dropping to 0 as slots fill. After ev_ready rises, events drain in order with nothing lost.
- Reset mid-operation: assert rst_n while S1 and the output register are full. Expect ev_valid = 0 immediately and in_ready = 4'b1111 after release. A subsequent ch2 = 0x03 then reports delta 0x03 against a baseline of 0.
- Counter saturation: force 65536+ events. Expect ev_cnt to hold at 0xFFFF.
